// File: rtl/md_unit_pkg.sv
// ============================================================================
// Package : md_unit_pkg
// Shared opcode encodings, FSM state type and helpers for the MIPS
// multiply/divide unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

package md_unit_pkg;

  // 3-bit multiply/divide operation codes (shared with decode and hazard logic)
  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2
  } md_state_t;

  // True for the four codes that launch a multi-cycle operation
  function automatic logic is_arith(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // True for the signed variants
  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

`default_nettype wire

// File: rtl/md_result.sv
// ============================================================================
// Module  : md_result
// Combinational 64-bit {hi,lo} result for multiply or divide on the latched
// operands, plus a divide-by-zero flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module md_result (
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        is_div,
  input  logic        is_signed,
  output logic [63:0] result,
  output logic        div_zero
);

  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] prod;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] safe_b;
  logic [31:0] quo;
  logic [31:0] rem;

  // Product via sign/zero extension; quotient/remainder via magnitudes with sign fix-up
  always_comb begin
    ext_a    = is_signed ? {{32{op_a[31]}}, op_a} : {32'd0, op_a};
    ext_b    = is_signed ? {{32{op_b[31]}}, op_b} : {32'd0, op_b};
    prod     = ext_a * ext_b;
    neg_a    = is_signed & op_a[31];
    neg_b    = is_signed & op_b[31];
    mag_a    = neg_a ? (32'd0 - op_a) : op_a;
    mag_b    = neg_b ? (32'd0 - op_b) : op_b;
    div_zero = (op_b == 32'd0);
    // Keep the divider free of X when the divisor is zero; result is discarded then
    safe_b   = div_zero ? 32'd1 : mag_b;
    quo      = mag_a / safe_b;
    rem      = mag_a % safe_b;
    // Quotient truncates toward zero; remainder follows the dividend's sign.
    // 0x80000000 / -1 naturally yields quo=0x80000000, rem=0.
    if (neg_a ^ neg_b) quo = 32'd0 - quo;
    if (neg_a)         rem = 32'd0 - rem;
    result   = is_div ? {rem, quo} : prod;
  end

endmodule

`default_nettype wire

// File: rtl/md_unit.sv
// ============================================================================
// Module  : md_unit
// Fixed-latency multiply/divide responder owning architectural HI/LO.
// Reports busy and remaining cycles to the hazard unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic        wr_hilo,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [4:0]  busy_cnt,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [4:0] MULT_LAT = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_LAT  = 5'(DIV_CYCLES);

  md_state_t   state;
  md_state_t   next_state;
  logic [4:0]  cnt;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_signed;
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;
  logic [63:0] res;
  logic        div_zero;
  logic        launch;
  logic        commit;

  // A launch only happens from IDLE; the commit edge is the last busy cycle
  assign launch = (state == ST_IDLE) && start && is_arith(md_op);
  assign commit = (state != ST_IDLE) && (cnt == 5'd1);

  md_result u_result (
    .op_a      (op_a),
    .op_b      (op_b),
    .is_div    (state == ST_DIV),
    .is_signed (op_signed),
    .result    (res),
    .div_zero  (div_zero)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (launch) begin
          next_state = ((md_op == MD_MULT) || (md_op == MD_MULTU)) ? ST_MULT : ST_DIV;
        end
      end
      ST_MULT, ST_DIV: begin
        if (commit) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy     = (state != ST_IDLE);
    busy_cnt = cnt;
    hi       = hi_reg;
    lo       = lo_reg;
  end

  // Counter, latched operands and HI/LO; start/mt requests while busy are ignored
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= 5'd0;
      op_a      <= 32'd0;
      op_b      <= 32'd0;
      op_signed <= 1'b0;
      hi_reg    <= 32'd0;
      lo_reg    <= 32'd0;
    end else if (launch) begin
      op_a      <= rs_val;
      op_b      <= rt_val;
      op_signed <= is_signed_op(md_op);
      cnt       <= ((md_op == MD_MULT) || (md_op == MD_MULTU)) ? MULT_LAT : DIV_LAT;
    end else if (state != ST_IDLE) begin
      cnt <= cnt - 5'd1;
      if (commit && !((state == ST_DIV) && div_zero)) begin
        hi_reg <= res[63:32];
        lo_reg <= res[31:0];
      end
    end else if (wr_hilo && !start) begin
      if (md_op == MD_MTHI) hi_reg <= rs_val;
      if (md_op == MD_MTLO) lo_reg <= rs_val;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_md_unit.sv
// ============================================================================
// Testbench : tb_md_unit
// Scoreboard-based self-checking bench for md_unit.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module tb_md_unit;
  import md_unit_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic        wr_hilo;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [4:0]  busy_cnt;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  logic [63:0] sb[$];
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .wr_hilo  (wr_hilo),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .busy     (busy),
    .busy_cnt (busy_cnt),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result of an operation given the current HI/LO
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] ch,
                                        input logic [31:0] cl);
    longint sa, sb_, q, r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    case (op)
      MD_MULT:  begin p = sa * sb_; return p; end
      MD_MULTU: begin p = {32'd0, a} * {32'd0, b}; return p; end
      MD_DIV: begin
        if (b == 32'd0) return {ch, cl};
        q = sa / sb_;
        r = sa % sb_;
        return {r[31:0], q[31:0]};
      end
      MD_DIVU: begin
        if (b == 32'd0) return {ch, cl};
        return {a % b, a / b};
      end
      default: return {ch, cl};
    endcase
  endfunction

  // Launch one op (caller is at a negedge), track busy cycle by cycle, then check commit.
  // inj_start / inj_mt: busy_cnt value at which an illegal start / mtlo is injected (0 = none)
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int inj_start, input int inj_mt);
    int n;
    logic [63:0] e;
    logic [63:0] got;
    n = ((op == MD_MULT) || (op == MD_MULTU)) ? MC : DC;
    start = 1'b1; md_op = op; rs_val = a; rt_val = b;
    e = model(op, a, b, exp_hi, exp_lo);
    sb.push_back(e);
    exp_hi = e[63:32];
    exp_lo = e[31:0];
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL start_cycle_busy op=%0d got=%b exp=0", op, busy);
    end
    @(negedge clk);
    start = 1'b0; md_op = MD_NONE;
    for (int i = n; i >= 1; i--) begin
      checks++;
      if (busy !== 1'b1 || busy_cnt !== 5'(i)) begin
        errors++;
        $display("FAIL busy_track op=%0d got busy=%b cnt=%0d exp busy=1 cnt=%0d", op, busy, busy_cnt, i);
      end
      if (i == inj_start) begin
        start = 1'b1; md_op = MD_MULTU; rs_val = 32'h0000_0F0F; rt_val = 32'h0000_0101;
      end
      if (i == inj_mt) begin
        wr_hilo = 1'b1; md_op = MD_MTLO; rs_val = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      start = 1'b0; wr_hilo = 1'b0; md_op = MD_NONE;
    end
    checks++;
    if (busy !== 1'b0 || busy_cnt !== 5'd0) begin
      errors++; $display("FAIL idle_after op=%0d got busy=%b cnt=%0d exp busy=0 cnt=0", op, busy, busy_cnt);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++; $display("FAIL scoreboard_empty op=%0d got=0 entries exp=1", op);
    end else begin
      got = {hi, lo};
      e = sb.pop_front();
      if (got !== e) begin
        errors++; $display("FAIL result op=%0d got=%h exp=%h", op, got, e);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; md_op = MD_NONE; wr_hilo = 1'b0; rs_val = '0; rt_val = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || busy_cnt !== 5'd0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL reset_state got busy=%b cnt=%0d hi=%h lo=%h exp 0", busy, busy_cnt, hi, lo);
    end
    reset = 1'b1;
    exp_hi = 32'd0; exp_lo = 32'd0;
    @(negedge clk);
  endtask

  task automatic test_mult;
    run_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, 0, 0);
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
      errors++; $display("FAIL mult_vector got hi=%h lo=%h exp hi=ffffffff lo=fffffffa", hi, lo);
    end
    run_op(MD_MULTU, 32'hFFFF_FFFE, 32'd3, 0, 0);
    checks++;
    if (hi !== 32'h0000_0002 || lo !== 32'hFFFF_FFFA) begin
      errors++; $display("FAIL multu_vector got hi=%h lo=%h exp hi=00000002 lo=fffffffa", hi, lo);
    end
  endtask

  task automatic test_div;
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0);
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      errors++; $display("FAIL div_vector got hi=%h lo=%h exp hi=ffffffff lo=fffffffd", hi, lo);
    end
    run_op(MD_DIV, 32'd7, 32'hFFFF_FFFE, 0, 0);
    run_op(MD_DIVU, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op(MD_DIVU, 32'd7, 32'd0, 0, 0);
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    checks++;
    if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
      errors++; $display("FAIL div_overflow got hi=%h lo=%h exp hi=00000000 lo=80000000", hi, lo);
    end
  endtask

  task automatic test_mthi_mtlo;
    wr_hilo = 1'b1; md_op = MD_MTHI; rs_val = 32'h1234_5678;
    @(negedge clk);
    checks++;
    if (hi !== 32'h1234_5678) begin
      errors++; $display("FAIL mthi got=%h exp=12345678", hi);
    end
    md_op = MD_MTLO; rs_val = 32'h9ABC_DEF0;
    @(negedge clk);
    checks++;
    if (lo !== 32'h9ABC_DEF0 || hi !== 32'h1234_5678) begin
      errors++; $display("FAIL mtlo got hi=%h lo=%h exp hi=12345678 lo=9abcdef0", hi, lo);
    end
    // start with a non-arithmetic code plus wr_hilo: start wins, mt dropped, nothing launches
    start = 1'b1; md_op = MD_MTHI; rs_val = 32'h5555_5555;
    @(negedge clk);
    start = 1'b0; wr_hilo = 1'b0; md_op = MD_NONE;
    checks++;
    if (hi !== 32'h1234_5678 || busy !== 1'b0) begin
      errors++; $display("FAIL start_beats_mt got hi=%h busy=%b exp hi=12345678 busy=0", hi, busy);
    end
    exp_hi = 32'h1234_5678; exp_lo = 32'h9ABC_DEF0;
  endtask

  task automatic test_busy_ignore;
    // mtlo at busy_cnt==5 and start at busy_cnt==3 during a DIV
    run_op(MD_DIV, 32'd100, 32'd7, 0, 5);
    run_op(MD_DIV, 32'hFFFF_FF9C, 32'd9, 3, 0);
    // start at the commit edge is ignored
    run_op(MD_MULT, 32'h0001_0000, 32'h0001_0000, 1, 0);
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 4; k++) begin
      run_op(3'($urandom_range(1, 4)), $urandom, (k == 2) ? 32'd0 : $urandom, 0, 0);
    end
  endtask

  task automatic test_reset_midflight;
    int guard;
    start = 1'b1; md_op = MD_MULT; rs_val = 32'h7FFF_FFFF; rt_val = 32'h0000_0003;
    @(negedge clk);
    start = 1'b0; md_op = MD_NONE;
    guard = 0;
    while (busy_cnt !== 5'd2 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 20) begin
      errors++; $display("FAIL reach_cnt2 got cnt=%0d exp=2", busy_cnt);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || busy_cnt !== 5'd0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL async_reset got busy=%b cnt=%0d hi=%h lo=%h exp 0", busy, busy_cnt, hi, lo);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL no_commit_after_reset got busy=%b hi=%h lo=%h exp 0", busy, hi, lo);
    end
    exp_hi = 32'd0; exp_lo = 32'd0;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_busy_ignore();
    test_back_to_back();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
